// File: rtl/tap_pkg.sv
// Shared defaults and helpers for the two-phase bundled-data receiver.
package tap_pkg;

  localparam int TAP_WIDTH       = 8;
  localparam int TAP_DEPTH       = 4;
  localparam int TAP_SYNC_STAGES = 2;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tap_rx_if.sv
// Sender handshake (req/ack/data_in) plus downstream valid/ready port.
interface tap_rx_if
  import tap_pkg::*;
#(
  parameter int WIDTH = TAP_WIDTH,
  parameter int DEPTH = TAP_DEPTH
);
  localparam int LW = clog2(DEPTH + 1);

  logic             req;
  logic [WIDTH-1:0] data_in;
  logic             ack;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;

  // Receiver side.
  modport slave (
    input  req, data_in, out_ready,
    output ack, out_valid, out_data, level
  );

  // Sender / consumer side.
  modport master (
    output req, data_in, out_ready,
    input  ack, out_valid, out_data, level
  );
endinterface

// File: rtl/tap_sync.sv
// Multi-flop synchronizer for the asynchronous req line.
module tap_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_pipe;

  // Shift req through the chain; all stages clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_pipe <= '0;
    else      sync_pipe <= {sync_pipe[STAGES-2:0], d};
  end

  assign q = sync_pipe[STAGES-1];
endmodule

// File: rtl/tap_rx.sv
// Two-phase req/ack receiver feeding an inline FIFO with valid/ready output.
module tap_rx
  import tap_pkg::*;
#(
  parameter int WIDTH       = TAP_WIDTH,
  parameter int DEPTH       = TAP_DEPTH,
  parameter int SYNC_STAGES = TAP_SYNC_STAGES
) (
  input  logic     clk,
  input  logic     rst,
  tap_rx_if.slave  bus
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = clog2(DEPTH + 1);

  logic             req_s;
  logic             ack_q;
  logic             pending;
  logic             full;
  logic             push;
  logic             pop;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] mem [DEPTH];

  tap_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.req),
    .q   (req_s)
  );

  // A token is outstanding whenever the synchronized req differs from ack.
  // Full is judged on the pre-edge level, so a full FIFO never pushes in
  // the same cycle it pops; the push lands on the following edge.
  assign pending = req_s ^ ack_q;
  assign full    = (level_q == LW'(DEPTH));
  assign push    = pending & ~full;
  assign pop     = (level_q != '0) & bus.out_ready;

  // Control state: ack toggles on acceptance, pointers wrap naturally
  // because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q   <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        ack_q <= ~ack_q;
        wptr  <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; stale words are never visible with level=0.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.data_in;
  end

  assign bus.ack       = ack_q;
  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = mem[rptr];
  assign bus.level     = level_q;
endmodule

// File: tb/tb_tap_rx.sv
// Self-checking bench for tap_rx: scoreboard of sent words vs popped words.
module tb_tap_rx;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;
  logic [WIDTH-1:0] exp_q [$];

  tap_rx_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  tap_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Wait for ack to catch up with req; returns edges taken (bounded).
  task automatic wait_ack(input int bound, output int lat);
    lat = 0;
    while (bus.ack !== bus.req && lat < bound) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Drive one token and check the accept latency.
  task automatic send(input logic [WIDTH-1:0] d, input string tag);
    int lat;
    @(negedge clk);
    bus.data_in = d;
    bus.req     = ~bus.req;
    exp_q.push_back(d);
    wait_ack(50, lat);
    chk(tag, lat, SS + 1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (bus.level !== '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.out_ready = 1'b0;
    chk(tag, bus.level, 0);
  endtask

  // Scoreboard: each pop must match the oldest word sent.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
      else chk("pop_data", bus.out_data, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic ack_hold;
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b0;
    bus.req = 1'b0;
    bus.data_in = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_level", bus.level, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single token
    send(8'hA5, "single_lat");
    chk("single_ack", bus.ack, 1);
    chk("single_valid", bus.out_valid, 1);
    chk("single_data", bus.out_data, 8'hA5);
    chk("single_level", bus.level, 1);
    drain("single_drain");

    // Burst to full, then a held fifth token
    for (int i = 1; i <= 4; i++) send(WIDTH'(i), "burst_lat");
    chk("burst_level", bus.level, 4);
    @(negedge clk);
    bus.data_in = 8'h05;
    bus.req     = ~bus.req;
    exp_q.push_back(8'h05);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data", bus.out_data, 8'h01);
      chk("full_hold", bus.ack ^ bus.req, 1);
    end
    chk("full_level", bus.level, 4);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("pop_no_push_level", bus.level, 3);
    wait_ack(20, lat);
    chk("fifth_accept", bus.ack ^ bus.req, 0);
    chk("fifth_level", bus.level, 4);
    drain("burst_drain");

    // Order and wrap with a free-running consumer
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(8'h10 + WIDTH'(i), "wrap_lat");
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b0;
    chk("wrap_level", bus.level, 0);
    chk("wrap_queue", exp_q.size(), 0);

    // Simultaneous push and pop at level 2
    send(8'h20, "sim_lat");
    send(8'h21, "sim_lat");
    @(negedge clk);
    bus.data_in = 8'h22;
    bus.req     = ~bus.req;
    exp_q.push_back(8'h22);
    @(negedge clk);
    @(negedge clk);
    chk("sim_pending", bus.ack ^ bus.req, 1);
    chk("sim_level_pre", bus.level, 2);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("sim_level_post", bus.level, 2);
    chk("sim_ack", bus.ack ^ bus.req, 0);
    drain("sim_drain");

    // Reset mid-operation with a pending token
    send(8'h41, "mid_lat");
    send(8'h42, "mid_lat");
    send(8'h43, "mid_lat");
    chk("mid_level", bus.level, 3);
    ack_hold = bus.ack;
    @(negedge clk);
    bus.data_in = 8'h44;
    bus.req     = ~bus.req;
    repeat (2) @(negedge clk);
    chk("mid_pending", bus.ack, ack_hold);
    rst = 1'b0;
    #1;
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_ack", bus.ack, 0);
    exp_q.delete();
    bus.req     = 1'b1;
    bus.data_in = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge clk);
    rst = 1'b1;
    wait_ack(50, lat);
    chk("post_rst_lat", lat, SS + 1);
    chk("post_rst_level", bus.level, 1);
    chk("post_rst_data", bus.out_data, 8'h55);
    drain("post_rst_drain");
    repeat (2) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/tap_rx.md
TAP_RX -- requirements
Module: tap_rx

Interface
REQ-001 Parameter WIDTH, default 8, width of the bundled data word.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; SHALL be a power of two, ≥2.
REQ-003 Parameter SYNC_STAGES, default 2, length of the req synchronizer chain; SHALL be ≥2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-low.
REQ-006 req  input  1  two-phase request from the sender; each transition is one token; asynchronous to clk.
REQ-007 data_in  input  WIDTH  bundled data; sender holds it stable from a req transition until the matching ack transition.
REQ-008 ack  output  1  two-phase acknowledge; toggles once per accepted token.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-011 out_data  output  WIDTH  oldest buffered word.
REQ-012 level  output  clog2(DEPTH+1)  number of buffered words.

Function
REQ-013 req SHALL pass through a SYNC_STAGES flop chain; req_s denotes the last stage.
REQ-014 Token pending SHALL equal req_s XOR ack.
REQ-015 When pending is high and level < DEPTH at a clock edge, data_in SHALL be written at the write pointer and ack SHALL toggle at that same edge.
REQ-016 When pending is high and level = DEPTH, no write SHALL occur and ack SHALL hold; the token stays pending, which stalls the sender.
REQ-017 Since ack is registered, pending clears at the edge of acceptance; each token SHALL be written exactly once.
REQ-018 Accept latency: with the FIFO not full, ack SHALL toggle SYNC_STAGES+1 rising edges after the req transition is first sampled.
REQ-019 out_valid SHALL equal (level ≠ 0); out_data SHALL come from a registered read pointer, with no combinational path from data_in.
REQ-020 A pop SHALL occur on an edge with out_valid and out_ready both high; the read pointer advances by one.
REQ-021 Pointers SHALL wrap modulo DEPTH.
REQ-022 level SHALL increment on push only, decrement on pop only, and stay unchanged on a simultaneous push and pop.
REQ-023 A full FIFO SHALL NOT accept a push in the same cycle as a pop; the push occurs on the following edge.
REQ-024 out_data SHALL be undefined-but-stable while out_valid is low, and SHALL NOT change while out_valid is high and out_ready is low.
REQ-025 Word order at out_data SHALL equal req token order.

Reset
REQ-026 While rst is low: ack=0, every synchronizer flop=0, level=0, both pointers=0, out_valid=0; FIFO contents are discarded.
REQ-027 If req=1 when rst is released, it SHALL be treated as one pending token after synchronization.
REQ-028 Reset during operation SHALL abort any pending token without toggling ack; the sender SHALL be reset together with this block (system rule).

Structure
REQ-029 Shared package tap_pkg SHALL hold the default WIDTH, DEPTH and SYNC_STAGES and a clog2 constant function.
REQ-030 The synchronizer SHALL be a separate sub-module tap_sync (parameter STAGES, async active-low reset); the FIFO SHALL be inline.

Verification
REQ-031 Single token: after reset, toggle req 0→1 with data_in=0xA5 -> ack goes 0→1 on edge 3; out_valid=1, out_data=0xA5, level=1.
REQ-032 Burst to full: with out_ready=0, send 5 tokens 0x01..0x05, each after the previous ack -> level=4 and ack toggles 4 times; the 5th is held until one pop, then 0x05 is accepted on a later edge.
REQ-033 Order and wrap: send 10 tokens 0x10..0x19 with out_ready=1 -> out_data sequence is 0x10..0x19 with no loss or duplication; pointers wrap twice.
REQ-034 Simultaneous push/pop: level=2, pending token and out_ready=1 on the same edge -> level stays 2 and ack toggles.
REQ-035 Reset mid-operation: level=3 plus a pending token, assert rst -> immediately level=0, out_valid=0, ack=0; after release with req=1, one token is accepted.
REQ-036 Backpressure stability: out_valid=1 with out_ready=0 for 5 cycles -> out_data is unchanged throughout.
